// File: rtl/tone_pkg.sv
// Shared types and default parameter values for the tone sequencer slice.
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } state_e;

  localparam int unsigned DEF_TONE_W       = 52;
  localparam int unsigned DEF_DUR_W        = 24;
  localparam int unsigned DEF_SHORT_CYCLES = 4;
  localparam int unsigned DEF_LONG_CYCLES  = 10;
  localparam int unsigned DEF_GAP_CYCLES   = 2;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;
  localparam int unsigned DEF_DEFAULT_TONE = 32000;

  // Queue entry layout at the default tone width.
  typedef struct packed {
    logic                  is_long;
    logic [DEF_TONE_W-1:0] tone;
  } tone_entry_t;

endpackage

// File: rtl/tone_fifo.sv
// Synchronous FIFO with count-based full/empty; a push into a full FIFO is
// accepted when a pop happens on the same edge.
module tone_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/tone_sequencer.sv
// Queued short/long beep generator: plays each FIFO entry for a fixed number
// of cycles, then a silent gap, driving the tone word and sound strobe.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned TONE_W       = DEF_TONE_W,
  parameter int unsigned DUR_W        = DEF_DUR_W,
  parameter int unsigned SHORT_CYCLES = DEF_SHORT_CYCLES,
  parameter int unsigned LONG_CYCLES  = DEF_LONG_CYCLES,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter logic [TONE_W-1:0] DEFAULT_TONE = TONE_W'(DEF_DEFAULT_TONE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              short_req,
  input  logic              long_req,
  input  logic              tone_load,
  input  logic [TONE_W-1:0] tone_in,
  output logic              s_enable,
  output logic [TONE_W-1:0] sonido,
  output logic              busy,
  output logic              full,
  output logic              dropped
);

  // Same layout as tone_entry_t, sized by TONE_W.
  typedef struct packed {
    logic              is_long;
    logic [TONE_W-1:0] tone;
  } entry_t;

  localparam logic [DUR_W-1:0] SHORT_LOAD = DUR_W'(SHORT_CYCLES - 1);
  localparam logic [DUR_W-1:0] LONG_LOAD  = DUR_W'(LONG_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? DUR_W'(GAP_CYCLES - 1) : '0;

  state_e            r_state, w_state_nx;
  logic [DUR_W-1:0]  r_cnt, w_cnt_nx;
  logic [TONE_W-1:0] r_tone;
  logic [TONE_W-1:0] r_play_tone, w_play_tone_nx;
  logic              r_s_enable, r_busy, r_dropped;
  logic [TONE_W-1:0] r_sonido;

  logic   w_req, w_push, w_pop, w_full, w_empty;
  entry_t w_push_entry, w_head;
  logic [TONE_W:0] w_rd_data;

  assign w_req                = short_req | long_req;
  assign w_push               = enable && w_req;
  assign w_push_entry.is_long = long_req;
  assign w_push_entry.tone    = tone_load ? tone_in : r_tone;
  assign w_head               = entry_t'(w_rd_data);

  tone_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TONE_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (w_push_entry),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_play_tone_nx = r_play_tone;
    w_pop          = 1'b0;
    if (enable) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            w_pop          = 1'b1;
            w_state_nx     = ST_PLAY;
            w_cnt_nx       = w_head.is_long ? LONG_LOAD : SHORT_LOAD;
            w_play_tone_nx = w_head.tone;
          end
        end
        // A zero-length gap folds the end-of-gap decision into the last PLAY cycle.
        ST_PLAY, ST_GAP: begin
          if (r_cnt != '0) begin
            w_cnt_nx = r_cnt - 1'b1;
          end else if (r_state == ST_PLAY && GAP_CYCLES > 0) begin
            w_state_nx = ST_GAP;
            w_cnt_nx   = GAP_LOAD;
          end else if (!w_empty) begin
            w_pop          = 1'b1;
            w_state_nx     = ST_PLAY;
            w_cnt_nx       = w_head.is_long ? LONG_LOAD : SHORT_LOAD;
            w_play_tone_nx = w_head.tone;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_play_tone <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_play_tone <= w_play_tone_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tone     <= DEFAULT_TONE;
      r_s_enable <= 1'b0;
      r_sonido   <= '0;
      r_busy     <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      if (tone_load) r_tone <= tone_in;
      r_s_enable <= enable && (r_state == ST_PLAY);
      r_sonido   <= (enable && (r_state == ST_PLAY)) ? r_play_tone : '0;
      r_busy     <= (r_state != ST_IDLE) || !w_empty;
      r_dropped  <= enable && w_req && w_full && !w_pop;
    end
  end

  assign s_enable = r_s_enable;
  assign sonido   = r_sonido;
  assign busy     = r_busy;
  assign full     = w_full;
  assign dropped  = r_dropped;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with SHORT=4, LONG=10, GAP=2, DEPTH=2.
module tb_tone_sequencer;

  localparam int unsigned TW = 52;

  logic          clk = 1'b0;
  logic          reset, enable, short_req, long_req, tone_load;
  logic [TW-1:0] tone_in;
  logic          s_enable, busy, full, dropped;
  logic [TW-1:0] sonido;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [TW-1:0] tone;
  logic          exp_se;

  tone_sequencer #(
    .TONE_W       (TW),
    .DUR_W        (24),
    .SHORT_CYCLES (4),
    .LONG_CYCLES  (10),
    .GAP_CYCLES   (2),
    .FIFO_DEPTH   (2),
    .DEFAULT_TONE (52'd32000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .short_req (short_req),
    .long_req  (long_req),
    .tone_load (tone_load),
    .tone_in   (tone_in),
    .s_enable  (s_enable),
    .sonido    (sonido),
    .busy      (busy),
    .full      (full),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; short_req = 1'b0; long_req = 1'b0;
    tone_load = 1'b0; tone_in = '0;
    tick; tick;
    chk("rst s_enable", 64'(s_enable), 64'd0);
    chk("rst sonido",   64'(sonido),   64'd0);
    chk("rst busy",     64'(busy),     64'd0);
    chk("rst full",     64'(full),     64'd0);
    chk("rst dropped",  64'(dropped),  64'd0);
    reset = 1'b0;

    // Single short beep from idle
    tone = 52'd32000;
    short_req = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      tick;
      short_req = 1'b0;
      exp_se = (c >= 2 && c <= 5);
      chk($sformatf("s1 se c%0d", c),   64'(s_enable), 64'(exp_se));
      chk($sformatf("s1 son c%0d", c),  64'(sonido),   exp_se ? 64'(tone) : 64'd0);
      chk($sformatf("s1 busy c%0d", c), 64'(busy),     64'(c >= 1 && c <= 7));
    end

    // Long then short on consecutive cycles
    long_req = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      tick;
      long_req  = 1'b0;
      short_req = (c == 0);
      exp_se = (c >= 2 && c <= 11) || (c >= 14 && c <= 17);
      chk($sformatf("s2 se c%0d", c),  64'(s_enable), 64'(exp_se));
      chk($sformatf("s2 son c%0d", c), 64'(sonido),   exp_se ? 64'(tone) : 64'd0);
    end
    chk("s2 busy end", 64'(busy), 64'd0);

    // Tone captured at request time; later load does not alter a playing beep
    tone_load = 1'b1; tone_in = 52'd1000;
    tick;
    tone_load = 1'b0;
    short_req = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      tick;
      short_req = 1'b0;
      tone_load = (c == 3);
      tone_in   = 52'd2000;
      exp_se = (c >= 2 && c <= 5);
      chk($sformatf("s3a se c%0d", c),  64'(s_enable), 64'(exp_se));
      chk($sformatf("s3a son c%0d", c), 64'(sonido),   exp_se ? 64'd1000 : 64'd0);
    end
    tone_load = 1'b0;
    short_req = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      tick;
      short_req = 1'b0;
      exp_se = (c >= 2 && c <= 5);
      chk($sformatf("s3b son c%0d", c), 64'(sonido), exp_se ? 64'd2000 : 64'd0);
    end
    // Both requests plus same-cycle load: one long entry carrying tone_in
    short_req = 1'b1; long_req = 1'b1; tone_load = 1'b1; tone_in = 52'd3000;
    for (int c = 0; c <= 13; c++) begin
      tick;
      short_req = 1'b0; long_req = 1'b0; tone_load = 1'b0;
      exp_se = (c >= 2 && c <= 11);
      chk($sformatf("s3c se c%0d", c),  64'(s_enable), 64'(exp_se));
      chk($sformatf("s3c son c%0d", c), 64'(sonido),   exp_se ? 64'd3000 : 64'd0);
    end
    tone = 52'd3000;

    // Four requests while a beep plays: two queued, two dropped
    short_req = 1'b1;
    for (int c = 0; c <= 23; c++) begin
      tick;
      short_req = (c >= 1 && c <= 4);
      exp_se = (c >= 2 && c <= 5) || (c >= 8 && c <= 11) || (c >= 14 && c <= 17);
      chk($sformatf("s4 se c%0d", c),   64'(s_enable), 64'(exp_se));
      chk($sformatf("s4 son c%0d", c),  64'(sonido),   exp_se ? 64'(tone) : 64'd0);
      chk($sformatf("s4 full c%0d", c), 64'(full),     64'(c >= 3 && c <= 6));
      chk($sformatf("s4 drop c%0d", c), 64'(dropped),  64'(c == 4 || c == 5));
      chk($sformatf("s4 busy c%0d", c), 64'(busy),     64'(c >= 1 && c <= 19));
    end

    // Pause for three cycles mid long beep; request during pause ignored
    long_req = 1'b1;
    for (int c = 0; c <= 19; c++) begin
      tick;
      long_req  = 1'b0;
      enable    = !(c >= 5 && c <= 7);
      short_req = (c == 6);
      exp_se = (c >= 2 && c <= 5) || (c >= 9 && c <= 14);
      chk($sformatf("s5 se c%0d", c),   64'(s_enable), 64'(exp_se));
      chk($sformatf("s5 son c%0d", c),  64'(sonido),   exp_se ? 64'(tone) : 64'd0);
      chk($sformatf("s5 drop c%0d", c), 64'(dropped),  64'd0);
      chk($sformatf("s5 busy c%0d", c), 64'(busy),     64'(c >= 1 && c <= 16));
    end
    enable = 1'b1; short_req = 1'b0;

    // Reset in the fifth high cycle of a long beep with one entry queued
    long_req = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      tick;
      long_req  = 1'b0;
      short_req = (c == 0);
      reset     = (c == 6);
      exp_se = (c >= 2 && c <= 6);
      chk($sformatf("s6 se c%0d", c),   64'(s_enable), 64'(exp_se));
      chk($sformatf("s6 son c%0d", c),  64'(sonido),   exp_se ? 64'(tone) : 64'd0);
      chk($sformatf("s6 busy c%0d", c), 64'(busy),     64'(c >= 1 && c <= 6));
      chk($sformatf("s6 full c%0d", c), 64'(full),     64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Parametrised beep generator for the buzzer output path. Accepts short and long beep requests, queues them in a small FIFO, and plays each one for a fixed number of clock cycles followed by a silent gap. It drives the tone word (`sonido`) and the sound-enable strobe (`s_enable`) consumed by the audio output stage. Successor to the fixed-frequency, unqueued short/long sound module.

## Interface
- `TONE_W`, 52: width of the tone word.
- `DUR_W`, 24: width of the duration counter.
- `SHORT_CYCLES`, 4: play length of a short beep in cycles; must be ≥1 and < 2^DUR_W.
- `LONG_CYCLES`, 10: play length of a long beep in cycles; must be ≥1.
- `GAP_CYCLES`, 2: silent cycles after each beep; 0 allowed.
- `FIFO_DEPTH`, 4: queued requests; power of two, ≥2.
- `DEFAULT_TONE`, 32000: tone register value after reset.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: global run/pause.
- `short_req` in 1: request a short beep. Sampled every enabled cycle.
- `long_req` in 1: request a long beep.
- `tone_load` in 1: load `tone_in` into the tone register.
- `tone_in` in TONE_W: new tone word.
- `s_enable` out 1: sound active. Registered.
- `sonido` out TONE_W: tone word while playing, 0 otherwise. Registered.
- `busy` out 1: FSM not IDLE or FIFO non-empty.
- `full` out 1: FIFO count == FIFO_DEPTH.
- `dropped` out 1: one-cycle pulse; a request was discarded.

## Operation
- Push: an enabled cycle with `short_req | long_req` writes one entry `{is_long, tone}`.
  - The entry holds the tone register value at that edge. When `tone_load` is asserted in the same cycle, the entry takes `tone_in`.
  - When both requests are asserted together, one long entry is written.
- Push when full: accepted only if a pop occurs in the same cycle. Otherwise the entry is discarded and `dropped` = 1 on the next cycle.
- FSM states:
  - IDLE: if FIFO non-empty, pop, load the counter with duration−1, go to PLAY.
  - PLAY: `s_enable`=1, `sonido`=entry tone. Counter decrements; at 0:
    - GAP_CYCLES>0: load GAP_CYCLES−1, go to GAP.
    - GAP_CYCLES=0: behave as the end of GAP.
  - GAP: outputs 0. Counter at 0: if FIFO non-empty, pop and go to PLAY; else go to IDLE.
- `enable`=0 (pause):
  - FSM, counter and FIFO hold.
  - Requests ignored; no `dropped` pulse.
  - `s_enable`, `sonido` forced to 0 from the next cycle.
  - On re-enable, the remaining duration resumes.
- `tone_load` acts regardless of `enable`. It does not alter entries already queued.
- Reset values:
  - IDLE, FIFO empty, counter 0.
  - Tone register = DEFAULT_TONE.
  - `s_enable`, `dropped`, `busy`, `full` = 0; `sonido` = 0.
- Reset mid-beep aborts it and flushes the queue. Outputs read 0 on the cycle after reset.

## Timing
- Request sampled at edge k; FIFO written at k.
- FSM pops at edge k+1; `s_enable`/`sonido` valid after edge k+2. Latency 2 cycles from an idle start.
- `s_enable` high for exactly SHORT_CYCLES or LONG_CYCLES enabled cycles, then low for exactly GAP_CYCLES before the next queued beep.
- With GAP_CYCLES=0, back-to-back beeps keep `s_enable` continuously high. `sonido` changes tone on the boundary cycle.
- `full`, `busy` reflect registered state; no combinational path from request inputs.
- `dropped` asserts the cycle after the rejected request.

## Structure
- Package `tone_pkg`:
  - State enum (IDLE, PLAY, GAP).
  - Entry struct `{is_long, tone}`.
  - Default parameter constants.
- Sub-module `tone_fifo`: synchronous FIFO with count-based `full`/`empty` and same-cycle push+pop support. Parametrised on depth and entry width.
- Top level holds the FSM, the duration counter, the tone register and the output registers.

## Test plan
Parameters for all scenarios: SHORT=4, LONG=10, GAP=2, DEPTH=2, DEFAULT_TONE=32000.
- Short pulse at cycle 0 after reset -> `s_enable`=1, `sonido`=32000 on cycles 2–5; 0 from cycle 6; `busy` drops at cycle 8.
- Long then short on consecutive cycles -> high 10 cycles, low 2, high 4. `sonido` 32000 throughout the high phases.
- `tone_load` with 1000, then short; next `tone_load` 2000 while playing -> `sonido`=1000 for the whole beep. A following request plays 2000.
- Four short requests, one per cycle, while a beep plays -> two queued, `full`=1, one or two `dropped` pulses per the pop timing. Exactly the queued beeps are played.
- `enable`=0 for 3 cycles midway through a long beep -> outputs 0 during the pause. Total high time is still 10 cycles.
- Reset asserted in cycle 5 of a long beep with one entry queued -> outputs 0 the next cycle, `busy`=0, no further beeps.
